// File: rtl/ahb_slaveport_arbiter_pkg.sv
// AHB-Lite transfer/burst encodings shared by the slaveport arbiter.
// burst_beats() gives the number of beats a NONSEQ burst holds the grant.
package ahb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001,
        WRAP4  = 3'b010,
        INCR4  = 3'b011,
        WRAP8  = 3'b100,
        INCR8  = 3'b101,
        WRAP16 = 3'b110,
        INCR16 = 3'b111
    } hburst_e;

    function automatic int unsigned burst_beats(
        input logic [2:0]  hburst,
        input int unsigned max_hold
    );
        int unsigned n;
        case (hburst)
            SINGLE:        n = 1;
            INCR:          n = max_hold;
            WRAP4, INCR4:  n = 4;
            WRAP8, INCR8:  n = 8;
            default:       n = 16;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ahb_slaveport_arbiter_picker.sv
// One-hot request picker: fixed priority (index 0 first) or
// round robin starting at the pointer.
module ahb_arb_picker
    import ahb_pkg::*;
#(
    parameter int MASTER   = 4,
    parameter int ARB_MODE = 1,
    parameter int PW       = 2
) (
    input  logic [MASTER-1:0] req_i,
    input  logic [PW-1:0]     ptr_i,
    output logic [MASTER-1:0] gnt_next_o
);

    logic [PW-1:0] idx;
    logic          found;

    // Scan masters in priority order and take the first requester
    always_comb begin
        gnt_next_o = '0;
        found      = 1'b0;
        idx        = '0;
        for (int k = 0; k < MASTER; k++) begin
            idx = (ARB_MODE == 0) ? PW'(k)
                : PW'((int'(ptr_i) + k) % MASTER);
            if (!found && req_i[idx]) begin
                gnt_next_o[idx] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_slaveport_arbiter.sv
// Per-slave AHB-Lite arbiter/mux with burst and lock hold,
// and separate address-phase and data-phase owners.
module ahb_slaveport_arbiter
    import ahb_pkg::*;
#(
    parameter int MASTER      = 4,
    parameter int HADDR_WIDTH = 32,
    parameter int HDATA_WIDTH = 32,
    parameter int ARB_MODE    = 1,
    parameter int MAX_HOLD    = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [MASTER-1:0]             mst_HSEL_i,
    input  logic [2*MASTER-1:0]           mst_HTRANS_i,
    input  logic [3*MASTER-1:0]           mst_HBURST_i,
    input  logic [3*MASTER-1:0]           mst_HSIZE_i,
    input  logic [MASTER-1:0]             mst_HWRITE_i,
    input  logic [MASTER*HADDR_WIDTH-1:0] mst_HADDR_i,
    input  logic [MASTER*HDATA_WIDTH-1:0] mst_HWDATA_i,
    input  logic [MASTER-1:0]             mst_HMASTLOCK_i,
    output logic [MASTER-1:0]             mst_HREADYOUT_o,
    output logic [MASTER*HDATA_WIDTH-1:0] mst_HRDATA_o,
    output logic [MASTER-1:0]             mst_HRESP_o,
    output logic [MASTER-1:0]             mst_grant_o,
    output logic                          slv_HSEL_o,
    output logic [1:0]                    slv_HTRANS_o,
    output logic [2:0]                    slv_HBURST_o,
    output logic [2:0]                    slv_HSIZE_o,
    output logic                          slv_HWRITE_o,
    output logic [HADDR_WIDTH-1:0]        slv_HADDR_o,
    output logic [HDATA_WIDTH-1:0]        slv_HWDATA_o,
    output logic                          slv_HMASTLOCK_o,
    output logic                          slv_HREADY_o,
    input  logic                          slv_HREADYOUT_i,
    input  logic [HDATA_WIDTH-1:0]        slv_HRDATA_i,
    input  logic                          slv_HRESP_i
);

    localparam int PW   = (MASTER > 1) ? $clog2(MASTER) : 1;
    localparam int HMAX = (MAX_HOLD > 16) ? MAX_HOLD : 16;
    localparam int CW   = $clog2(HMAX + 1);

    logic [MASTER-1:0]      grant_q, grant_d;
    logic [MASTER-1:0]      down_q, down_d;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d, rem;
    logic                   err_q, err_d;
    logic [MASTER-1:0]      req, gnt_next;
    logic                   own_sel, own_lock, own_write;
    logic [1:0]             own_trans;
    logic [2:0]             own_burst, own_size;
    logic [HADDR_WIDTH-1:0] own_addr;
    logic [HDATA_WIDTH-1:0] dat_wdata;
    logic                   has_own, own_req, acc, rel, arb;

    // A master requests when selected with NONSEQ or SEQ
    always_comb begin
        req = '0;
        for (int i = 0; i < MASTER; i++)
            req[i] = mst_HSEL_i[i] & mst_HTRANS_i[2*i+1];
    end

    ahb_arb_picker #(
        .MASTER   (MASTER),
        .ARB_MODE (ARB_MODE),
        .PW       (PW)
    ) u_picker (
        .req_i      (req),
        .ptr_i      (ptr_q),
        .gnt_next_o (gnt_next)
    );

    // Select address-phase signals of the owner and HWDATA of the data owner
    always_comb begin
        own_sel   = 1'b0;
        own_lock  = 1'b0;
        own_write = 1'b0;
        own_trans = IDLE;
        own_burst = '0;
        own_size  = '0;
        own_addr  = '0;
        dat_wdata = '0;
        for (int i = 0; i < MASTER; i++) begin
            if (grant_q[i]) begin
                own_sel   = mst_HSEL_i[i];
                own_lock  = mst_HMASTLOCK_i[i];
                own_write = mst_HWRITE_i[i];
                own_trans = mst_HTRANS_i[2*i +: 2];
                own_burst = mst_HBURST_i[3*i +: 3];
                own_size  = mst_HSIZE_i[3*i +: 3];
                own_addr  = mst_HADDR_i[i*HADDR_WIDTH +: HADDR_WIDTH];
            end
            if (down_q[i])
                dat_wdata = mst_HWDATA_i[i*HDATA_WIDTH +: HDATA_WIDTH];
        end
    end

    // Decide arbitration point and next owner, pointer and beat count
    always_comb begin
        has_own = |grant_q;
        own_req = |(grant_q & req);
        acc     = slv_HREADYOUT_i & own_req;
        if (own_trans == NONSEQ)
            rem = CW'(burst_beats(own_burst, MAX_HOLD) - 1);
        else
            rem = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        rel = ~own_sel | (own_trans == IDLE)
            | (acc & (rem == '0)) | err_q;
        arb = slv_HREADYOUT_i & (~has_own | (~own_lock & rel));

        grant_d = arb ? gnt_next : grant_q;
        ptr_d   = ptr_q;
        for (int i = 0; i < MASTER; i++)
            if (arb && gnt_next[i])
                ptr_d = (i == MASTER - 1) ? '0 : PW'(i + 1);

        err_d  = (|down_q) & slv_HRESP_i & ~slv_HREADYOUT_i;
        cnt_d  = acc ? rem : cnt_q;
        if (err_d)
            cnt_d = '0;
        down_d = slv_HREADYOUT_i ? (acc ? grant_q : '0) : down_q;
    end

    // Owner registers, pointer, beat counter and error flag
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            grant_q <= '0;
            down_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            grant_q <= grant_d;
            down_q  <= down_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Drive the slave side from the address owner
    always_comb begin
        mst_grant_o     = grant_q;
        slv_HSEL_o      = own_req;
        slv_HTRANS_o    = own_req ? own_trans : IDLE;
        slv_HBURST_o    = own_burst;
        slv_HSIZE_o     = own_size;
        slv_HWRITE_o    = own_write;
        slv_HADDR_o     = own_addr;
        slv_HWDATA_o    = dat_wdata;
        slv_HMASTLOCK_o = own_lock;
        slv_HREADY_o    = slv_HREADYOUT_i;
    end

    // Route responses to the data owner; stall waiting requesters
    always_comb begin
        mst_HREADYOUT_o = '1;
        mst_HRESP_o     = '0;
        mst_HRDATA_o    = '0;
        for (int i = 0; i < MASTER; i++) begin
            if (down_q[i]) begin
                mst_HREADYOUT_o[i] = slv_HREADYOUT_i;
                mst_HRESP_o[i]     = slv_HRESP_i;
                mst_HRDATA_o[i*HDATA_WIDTH +: HDATA_WIDTH] = slv_HRDATA_i;
            end else if (grant_q[i]) begin
                mst_HREADYOUT_o[i] = slv_HREADYOUT_i;
            end else if (req[i]) begin
                mst_HREADYOUT_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_slaveport_arbiter.sv
// Directed bench for ahb_slaveport_arbiter: one round-robin and one
// fixed-priority instance driven by the same master/slave stimulus.
module tb_ahb_slaveport_arbiter;

    logic         clk = 1'b0;
    logic         rstn;
    logic [3:0]   sel, lock, wr;
    logic [7:0]   trans;
    logic [11:0]  burst, size;
    logic [127:0] haddr, hwdata;
    logic         rdy, resp;
    logic [31:0]  rdata;

    logic [3:0]   r_hrdy, r_hresp, r_grant;
    logic [127:0] r_hrdata;
    logic         r_ssel, r_swrite, r_slock, r_sready;
    logic [1:0]   r_strans;
    logic [2:0]   r_sburst, r_ssize;
    logic [31:0]  r_saddr, r_swdata;

    logic [3:0]   f_hrdy, f_hresp, f_grant;
    logic [127:0] f_hrdata;
    logic         f_ssel, f_swrite, f_slock, f_sready;
    logic [1:0]   f_strans;
    logic [2:0]   f_sburst, f_ssize;
    logic [31:0]  f_saddr, f_swdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ahb_slaveport_arbiter #(.ARB_MODE(1)) u_rr (
        .HCLK            (clk),
        .HRESETn         (rstn),
        .mst_HSEL_i      (sel),
        .mst_HTRANS_i    (trans),
        .mst_HBURST_i    (burst),
        .mst_HSIZE_i     (size),
        .mst_HWRITE_i    (wr),
        .mst_HADDR_i     (haddr),
        .mst_HWDATA_i    (hwdata),
        .mst_HMASTLOCK_i (lock),
        .mst_HREADYOUT_o (r_hrdy),
        .mst_HRDATA_o    (r_hrdata),
        .mst_HRESP_o     (r_hresp),
        .mst_grant_o     (r_grant),
        .slv_HSEL_o      (r_ssel),
        .slv_HTRANS_o    (r_strans),
        .slv_HBURST_o    (r_sburst),
        .slv_HSIZE_o     (r_ssize),
        .slv_HWRITE_o    (r_swrite),
        .slv_HADDR_o     (r_saddr),
        .slv_HWDATA_o    (r_swdata),
        .slv_HMASTLOCK_o (r_slock),
        .slv_HREADY_o    (r_sready),
        .slv_HREADYOUT_i (rdy),
        .slv_HRDATA_i    (rdata),
        .slv_HRESP_i     (resp)
    );

    ahb_slaveport_arbiter #(.ARB_MODE(0)) u_fx (
        .HCLK            (clk),
        .HRESETn         (rstn),
        .mst_HSEL_i      (sel),
        .mst_HTRANS_i    (trans),
        .mst_HBURST_i    (burst),
        .mst_HSIZE_i     (size),
        .mst_HWRITE_i    (wr),
        .mst_HADDR_i     (haddr),
        .mst_HWDATA_i    (hwdata),
        .mst_HMASTLOCK_i (lock),
        .mst_HREADYOUT_o (f_hrdy),
        .mst_HRDATA_o    (f_hrdata),
        .mst_HRESP_o     (f_hresp),
        .mst_grant_o     (f_grant),
        .slv_HSEL_o      (f_ssel),
        .slv_HTRANS_o    (f_strans),
        .slv_HBURST_o    (f_sburst),
        .slv_HSIZE_o     (f_ssize),
        .slv_HWRITE_o    (f_swrite),
        .slv_HADDR_o     (f_saddr),
        .slv_HWDATA_o    (f_swdata),
        .slv_HMASTLOCK_o (f_slock),
        .slv_HREADY_o    (f_sready),
        .slv_HREADYOUT_i (rdy),
        .slv_HRDATA_i    (rdata),
        .slv_HRESP_i     (resp)
    );

    typedef struct packed {
        logic        rst;
        logic [3:0]  sel;
        logic [7:0]  trans;
        logic [11:0] burst;
        logic [3:0]  g_rr;
        logic [3:0]  g_fx;
        logic [3:0]  r_rr;
        logic [3:0]  r_fx;
        logic [1:0]  st;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn  = 1'b0;
        sel   = '0;
        trans = '0;
        burst = '0;
        lock  = '0;
        rdy   = 1'b1;
        resp  = 1'b0;
        rdata = '0;
        tick();
        tick();
        rstn  = 1'b1;
    endtask

    initial begin
        size = '0;
        wr   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            haddr[i*32 +: 32]  = 32'h1000 * (i + 1);
            hwdata[i*32 +: 32] = 32'hA000_0000 | i;
        end

        // RR vs fixed, all four masters issuing continuous SINGLEs
        vt[0]  = '{1'b1, 4'hF, 8'hAA, 12'h000, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0};
        vt[1]  = '{1'b0, 4'hF, 8'hAA, 12'h000, 4'h1, 4'h1, 4'h1, 4'h1, 2'd2};
        vt[2]  = '{1'b0, 4'hF, 8'hAA, 12'h000, 4'h2, 4'h1, 4'h3, 4'h1, 2'd2};
        vt[3]  = '{1'b0, 4'hF, 8'hAA, 12'h000, 4'h4, 4'h1, 4'h6, 4'h1, 2'd2};
        vt[4]  = '{1'b0, 4'hF, 8'hAA, 12'h000, 4'h8, 4'h1, 4'hC, 4'h1, 2'd2};
        vt[5]  = '{1'b0, 4'hF, 8'hAA, 12'h000, 4'h1, 4'h1, 4'h9, 4'h1, 2'd2};
        // M1 INCR4, M0 joins at beat 2
        vt[6]  = '{1'b1, 4'h2, 8'h08, 12'h018, 4'h0, 4'h0, 4'hD, 4'hD, 2'd0};
        vt[7]  = '{1'b0, 4'h2, 8'h08, 12'h018, 4'h2, 4'h2, 4'hF, 4'hF, 2'd2};
        vt[8]  = '{1'b0, 4'h3, 8'h0E, 12'h018, 4'h2, 4'h2, 4'hE, 4'hE, 2'd3};
        vt[9]  = '{1'b0, 4'h3, 8'h0E, 12'h018, 4'h2, 4'h2, 4'hE, 4'hE, 2'd3};
        vt[10] = '{1'b0, 4'h3, 8'h0E, 12'h018, 4'h2, 4'h2, 4'hE, 4'hE, 2'd3};
        vt[11] = '{1'b0, 4'h1, 8'h02, 12'h018, 4'h1, 4'h1, 4'hF, 4'hF, 2'd2};

        do_reset();
        @(negedge clk);
        chk("rst grant", 32'(r_grant), 32'h0);
        chk("rst htrans", 32'(r_strans), 32'h0);
        chk("rst hsel", 32'(r_ssel), 32'h0);
        chk("rst hreadyout", 32'(r_hrdy), 32'hF);
        chk("rst hresp", 32'(r_hresp), 32'h0);
        chk("rst hready", 32'(r_sready), 32'h1);
        chk("rst grant fx", 32'(f_grant), 32'h0);
        tick();

        for (int i = 0; i < 12; i++) begin
            if (vt[i].rst)
                do_reset();
            sel   = vt[i].sel;
            trans = vt[i].trans;
            burst = vt[i].burst;
            @(negedge clk);
            chk($sformatf("v%0d grant rr", i), 32'(r_grant), 32'(vt[i].g_rr));
            chk($sformatf("v%0d grant fx", i), 32'(f_grant), 32'(vt[i].g_fx));
            chk($sformatf("v%0d hrdy rr", i), 32'(r_hrdy), 32'(vt[i].r_rr));
            chk($sformatf("v%0d hrdy fx", i), 32'(f_hrdy), 32'(vt[i].r_fx));
            chk($sformatf("v%0d htrans rr", i), 32'(r_strans), 32'(vt[i].st));
            chk($sformatf("v%0d htrans fx", i), 32'(f_strans), 32'(vt[i].st));
            tick();
        end

        // M2 locked INCR for 20 beats while M0 keeps requesting
        do_reset();
        sel   = 4'b0100;
        trans = 8'h20;
        burst = 12'h040;
        lock  = 4'b0100;
        @(negedge clk);
        tick();
        for (int c = 1; c <= 20; c++) begin
            sel   = 4'b0101;
            trans = (c == 1) ? 8'h22 : 8'h32;
            @(negedge clk);
            chk($sformatf("lock c%0d grant rr", c), 32'(r_grant), 32'h4);
            chk($sformatf("lock c%0d grant fx", c), 32'(f_grant), 32'h4);
            if (c == 10)
                chk("lock hmastlock", 32'(r_slock), 32'h1);
            if (c == 20)
                chk("lock m0 stall", 32'(r_hrdy[0]), 32'h0);
            tick();
        end
        trans = 8'h02;
        lock  = 4'b0000;
        @(negedge clk);
        chk("lock idle grant", 32'(r_grant), 32'h4);
        tick();
        @(negedge clk);
        chk("lock switch rr", 32'(r_grant), 32'h1);
        chk("lock switch fx", 32'(f_grant), 32'h1);
        chk("lock switch htrans", 32'(r_strans), 32'h2);
        tick();

        // Same M2 INCR without lock: hold limit of 16 beats
        do_reset();
        sel   = 4'b0100;
        trans = 8'h20;
        burst = 12'h040;
        @(negedge clk);
        tick();
        for (int c = 1; c <= 17; c++) begin
            sel   = 4'b0101;
            trans = (c == 1) ? 8'h22 : 8'h32;
            @(negedge clk);
            chk($sformatf("hold c%0d grant rr", c), 32'(r_grant),
                (c <= 16) ? 32'h4 : 32'h1);
            chk($sformatf("hold c%0d grant fx", c), 32'(f_grant),
                (c <= 16) ? 32'h4 : 32'h1);
            tick();
        end

        // Slave ERROR on M3 beat 2 of INCR8, M1 pending
        do_reset();
        sel   = 4'b1000;
        trans = 8'h80;
        burst = 12'hA00;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("err c1 grant", 32'(r_grant), 32'h8);
        tick();
        sel   = 4'b1010;
        trans = 8'hC8;
        rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("err c2 hrdata", r_hrdata[127:96], 32'hDEAD_BEEF);
        chk("err c2 hwdata", r_swdata, 32'hA000_0003);
        chk("err c2 haddr", r_saddr, 32'h4000);
        chk("err c2 m1 stall", 32'(r_hrdy[1]), 32'h0);
        tick();
        rdy  = 1'b0;
        resp = 1'b1;
        @(negedge clk);
        chk("err c3 hresp rr", 32'(r_hresp[3]), 32'h1);
        chk("err c3 hrdy rr", 32'(r_hrdy[3]), 32'h0);
        chk("err c3 hresp fx", 32'(f_hresp[3]), 32'h1);
        chk("err c3 m1 stall", 32'(r_hrdy[1]), 32'h0);
        tick();
        rdy   = 1'b1;
        trans = 8'h08;
        @(negedge clk);
        chk("err c4 hresp", 32'(r_hresp[3]), 32'h1);
        chk("err c4 hrdy", 32'(r_hrdy[3]), 32'h1);
        chk("err c4 grant", 32'(r_grant), 32'h8);
        tick();
        resp = 1'b0;
        @(negedge clk);
        chk("err c5 grant rr", 32'(r_grant), 32'h2);
        chk("err c5 grant fx", 32'(f_grant), 32'h2);
        chk("err c5 hresp", 32'(r_hresp[3]), 32'h0);
        chk("err c5 hsel", 32'(r_ssel), 32'h1);
        chk("err c5 m1 hrdy", 32'(r_hrdy[1]), 32'h1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
